// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared types for the mrv32 instruction decode stage.
//   - RV32I major opcode constants
//   - op_class_t / alu_op_t / imm_type_t enums (the MULDIV ALU codes always
//     exist so widths do not depend on the RV32M build option)
//   - dec_bundle_t, the registered decode result handed to execute
//   - dec_state_t, decode register occupancy state
//   - small funct3 -> alu_op helpers
package mrv32_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // OC_NONE (zero) is used for illegal instructions and the reset bundle.
    typedef enum logic [3:0] {
        OC_NONE, OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BRANCH, OC_LOAD,
        OC_STORE, OC_OP_IMM, OC_OP, OC_MISC_MEM, OC_SYSTEM, OC_MULDIV
    } op_class_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    // IMM_R yields a zero immediate.
    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    typedef enum logic {D_EMPTY, D_FULL} dec_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        op_class_t   op_class;
        alu_op_t     alu_op;
        imm_type_t   imm_type;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
    } dec_bundle_t;

    // Base integer op selected by funct3 (SUB/SRA are chosen by funct7).
    function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t muldiv_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/mrv32_imm_gen.sv
// mrv32_imm_gen: combinational RV32I immediate generator.
// Ports:
//   instr    in  [31:7] instruction bits above the opcode
//   imm_type in  immediate format select
//   imm      out 32-bit sign-extended immediate (zero for IMM_R)
module mrv32_imm_gen
    import mrv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/mrv32_decode.sv
// mrv32_decode: RV32I decode register stage between fetch and execute.
// Captures a one-cycle instr_valid pulse, decodes it combinationally and
// holds the result in a single-entry register offered to execute.
// Handshake: dec_out is valid while dec_valid=1; it is consumed on any cycle
// where dec_valid && dec_ready, and stays bit-stable while dec_ready=0.
// Optional feature: define MRV32_DECODE_RV32M_EN to decode the RV32M
// MUL/DIV group (OP with funct7=0000001); otherwise those encodings are
// illegal.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   instr, pc    fetched instruction word and its PC
//   instr_valid  one-cycle pulse qualifying instr/pc
//   flush        discard the held entry (highest priority)
//   dec_out      registered decode bundle
//   dec_valid    dec_out holds an instruction (state D_FULL)
//   dec_ready    execute consumes dec_out this cycle
//   dec_overrun  sticky: an instr_valid pulse was dropped
// Parameters:
//   SUPPRESS_X0_WE       force reg_we=0 when rd==0
//   FLUSH_KEEPS_OVERRUN  flush leaves dec_overrun untouched
module mrv32_decode
    import mrv32_pkg::*;
#(
    parameter bit SUPPRESS_X0_WE      = 1'b1,
    parameter bit FLUSH_KEEPS_OVERRUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic        flush,
    output dec_bundle_t dec_out,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic        dec_overrun
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    op_class_t   op_class;
    alu_op_t     alu_op;
    imm_type_t   imm_type;
    logic        reg_we_raw, mem_re, mem_we;
    logic        is_branch, is_jal, is_jalr, illegal;
    logic [31:0] imm;
    dec_bundle_t dec_next;
    dec_state_t  state, state_next;
    logic        capture;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        op_class   = OC_NONE;
        alu_op     = ALU_ADD;
        imm_type   = IMM_R;
        reg_we_raw = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                op_class = OC_LUI; imm_type = IMM_U; reg_we_raw = 1'b1;
            end
            OPC_AUIPC: begin
                op_class = OC_AUIPC; imm_type = IMM_U; reg_we_raw = 1'b1;
            end
            OPC_JAL: begin
                op_class = OC_JAL; imm_type = IMM_J; reg_we_raw = 1'b1;
                is_jal = 1'b1;
            end
            OPC_JALR: begin
                op_class = OC_JALR; imm_type = IMM_I; reg_we_raw = 1'b1;
                is_jalr = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                op_class = OC_BRANCH; imm_type = IMM_B; is_branch = 1'b1;
                // BEQ/BNE compare by subtraction, BLT/BGE(U) by set-less-than.
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                op_class = OC_LOAD; imm_type = IMM_I; reg_we_raw = 1'b1;
                mem_re = 1'b1;
                illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                op_class = OC_STORE; imm_type = IMM_S; mem_we = 1'b1;
                illegal = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                op_class = OC_OP_IMM; imm_type = IMM_I; reg_we_raw = 1'b1;
                alu_op = base_alu_op(funct3);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                    else                      illegal = (funct7 != 7'b0000000);
                end
            end
            OPC_OP: begin
                op_class = OC_OP; reg_we_raw = 1'b1;
                alu_op = base_alu_op(funct3);
                if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    alu_op = ALU_SRA;
`ifdef MRV32_DECODE_RV32M_EN
                end else if (funct7 == 7'b0000001) begin
                    op_class = OC_MULDIV;
                    alu_op   = muldiv_alu_op(funct3);
`endif
                end else if (funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: op_class = OC_MISC_MEM;
            OPC_SYSTEM: begin
                op_class = OC_SYSTEM;
                // Only ECALL (imm=0) and EBREAK (imm=1) with rs1/funct3/rd zero.
                illegal = (instr[31:21] != 11'd0) || (instr[19:7] != 13'd0);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            op_class   = OC_NONE;
            reg_we_raw = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            is_branch  = 1'b0;
            is_jal     = 1'b0;
            is_jalr    = 1'b0;
        end
    end

    mrv32_imm_gen u_imm_gen (
        .instr    (instr[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    always_comb begin
        dec_next           = '0;
        dec_next.pc        = pc;
        dec_next.instr     = instr;
        dec_next.rs1       = instr[19:15];
        dec_next.rs2       = instr[24:20];
        dec_next.rd        = instr[11:7];
        dec_next.funct3    = funct3;
        dec_next.funct7    = funct7;
        dec_next.imm       = imm;
        dec_next.op_class  = op_class;
        dec_next.alu_op    = alu_op;
        dec_next.imm_type  = imm_type;
        dec_next.reg_we    = reg_we_raw && !(SUPPRESS_X0_WE && instr[11:7] == 5'd0);
        dec_next.mem_re    = mem_re;
        dec_next.mem_we    = mem_we;
        dec_next.is_branch = is_branch;
        dec_next.is_jal    = is_jal;
        dec_next.is_jalr   = is_jalr;
        dec_next.illegal   = illegal;
    end

    // A new instruction may enter when the register is empty or is being
    // drained by execute in the same cycle.
    assign capture = instr_valid && !flush && (state == D_EMPTY || dec_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= D_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)                              state_next = D_EMPTY;
        else if (capture)                       state_next = D_FULL;
        else if (state == D_FULL && dec_ready)  state_next = D_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dec_out <= '0;
        else if (capture) dec_out <= dec_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dec_overrun <= 1'b0;
        else if (flush && !FLUSH_KEEPS_OVERRUN)
            dec_overrun <= 1'b0;
        else if (instr_valid && !flush && state == D_FULL && !dec_ready)
            dec_overrun <= 1'b1;
    end

    assign dec_valid = (state == D_FULL);

endmodule
